// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix pins and key-event outputs of the keypad scanner
interface keypad_scanner_if;
  logic [3:0]  row_i;
  logic [3:0]  col_o;
  logic        key_valid_o;
  logic [3:0]  key_code_o;
  logic [15:0] bcd_o;
  modport master (output row_i, input col_o, key_valid_o, key_code_o, bcd_o);
  modport slave (input row_i, output col_o, key_valid_o, key_code_o, bcd_o);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad scan/debounce with key events; KEYPAD_BCD_ACCUM_EN adds a 4-digit BCD entry accumulator
module keypad_scanner #(
  parameter int SCAN_PERIOD    = 27000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  keypad_scanner_if.slave kp
);
  localparam int TW = $clog2(SCAN_PERIOD);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0] TICK_RELOAD = TW'(SCAN_PERIOD - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [1:0] SCAN = 2'd0, DEBOUNCE = 2'd1, HELD = 2'd2;
  // code per position 4*row+col, position 0 in the low nibble
  localparam logic [63:0] KEY_MAP = {4'd13, 4'd15, 4'd0, 4'd14, 4'd12, 4'd9, 4'd8, 4'd7,
                                     4'd11, 4'd6, 4'd5, 4'd4, 4'd10, 4'd3, 4'd2, 4'd1};
  logic [3:0]    sync1_q, sync2_q;
  logic [TW-1:0] tick_q;
  logic [1:0]    state_q, state_d, c_q, c_d, r_lock_q, r_lock_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q;
  logic [3:0]    code_q, code_d;
  logic          tick, any_low, lock_low, accept;
  logic [1:0]    low_row, row_sel;
  logic [3:0]    key_code;
  assign tick     = tick_q == '0;
  assign any_low  = ~&sync2_q;
  assign low_row  = ~sync2_q[0] ? 2'd0 : ~sync2_q[1] ? 2'd1 : ~sync2_q[2] ? 2'd2 : 2'd3;
  assign lock_low = ~sync2_q[r_lock_q];
  assign row_sel  = state_q == SCAN ? low_row : r_lock_q;
  assign key_code = KEY_MAP[{row_sel, c_q, 2'b00} +: 4];
  // a single-tick debounce accepts straight from the SCAN detection tick
  assign accept = tick & ((state_q == SCAN && any_low && DEBOUNCE_TICKS == 1) ||
                          (state_q == DEBOUNCE && lock_low && cnt_q == CNT_LAST));
  assign code_d = accept ? key_code : code_q;
  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    r_lock_d = r_lock_q;
    cnt_d    = cnt_q;
    if (accept) begin
      state_d = HELD;
      cnt_d   = '0;
      r_lock_d = row_sel;
    end else if (tick) begin
      case (state_q)
        SCAN: begin
          r_lock_d = any_low ? low_row : r_lock_q;
          cnt_d    = any_low ? CNT_ONE : cnt_q;
          state_d  = any_low ? DEBOUNCE : SCAN;
          c_d      = any_low ? c_q : c_q + 2'd1;
        end
        DEBOUNCE: begin
          state_d = lock_low ? DEBOUNCE : SCAN;
          c_d     = lock_low ? c_q : c_q + 2'd1;
          cnt_d   = cnt_q + CNT_ONE;
        end
        HELD: begin
          cnt_d   = lock_low ? '0 : cnt_q + CNT_ONE;
          state_d = !lock_low && cnt_q + CNT_ONE == CNT_DONE ? SCAN : HELD;
          c_d     = !lock_low && cnt_q + CNT_ONE == CNT_DONE ? c_q + 2'd1 : c_q;
        end
        default: state_d = SCAN;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 4'hF;
      sync2_q  <= 4'hF;
      tick_q   <= TICK_RELOAD;
      state_q  <= SCAN;
      c_q      <= 2'd0;
      r_lock_q <= 2'd0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      code_q   <= 4'd0;
    end else begin
      sync1_q  <= kp.row_i;
      sync2_q  <= sync1_q;
      tick_q   <= tick ? TICK_RELOAD : tick_q - 1'b1;
      state_q  <= state_d;
      c_q      <= c_d;
      r_lock_q <= r_lock_d;
      cnt_q    <= cnt_d;
      valid_q  <= accept;
      code_q   <= code_d;
    end
  end
  assign kp.col_o       = ~(4'b0001 << c_q);
  assign kp.key_valid_o = valid_q;
  assign kp.key_code_o  = code_q;
`ifdef KEYPAD_BCD_ACCUM_EN
  logic [15:0] bcd_q, bcd_d;
  assign bcd_d = !accept ? bcd_q : key_code <= 4'd9 ? {bcd_q[11:0], key_code} :
                 key_code == 4'd14 ? 16'h0000 : bcd_q;
  always_ff @(posedge clk_i) begin
    bcd_q <= rst_i ? 16'h0000 : bcd_d;
  end
  assign kp.bcd_o = bcd_q;
`else
  assign kp.bcd_o = 16'h0000;
`endif
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scan, debounce, key codes and BCD entry with a keypad matrix model
module tb_keypad_scanner;
`ifdef KEYPAD_BCD_ACCUM_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif
  typedef struct {
    logic [15:0] keys;
    int          cycles;
    int          pulses;
    logic [3:0]  code;
    logic [15:0] bcd;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        direct_en = 1'b1;
  logic [3:0]  direct_row = 4'hF;
  logic [15:0] keys = 16'h0000;
  logic [3:0]  row_model;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl [22];
  keypad_scanner_if kp ();
  keypad_scanner #(.SCAN_PERIOD(4), .DEBOUNCE_TICKS(3)) dut (.clk_i(clk), .rst_i(rst), .kp(kp));
  always #5 clk = ~clk;
  always_comb begin
    row_model = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !kp.col_o[c]) row_model[r] = 1'b0;
  end
  assign kp.row_i = direct_en ? direct_row : row_model;
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic run(input int n, output int p);
    p = 0;
    repeat (n) begin
      @(negedge clk);
      p += int'(kp.key_valid_o);
    end
  endtask
  task automatic do_reset();
    int p;
    rst = 1'b1;
    run(2, p);
    rst = 1'b0;
  endtask
  initial begin
    int p, q;
    tbl[0]  = '{16'h0000, 20, 0, 4'd0,  16'h0000};
    tbl[1]  = '{16'h0040, 40, 1, 4'd6,  16'h0006};
    tbl[2]  = '{16'h0040, 40, 0, 4'd6,  16'h0006};
    tbl[3]  = '{16'h0000, 24, 0, 4'd6,  16'h0006};
    tbl[4]  = '{16'h0001, 40, 1, 4'd1,  16'h0061};
    tbl[5]  = '{16'h0000, 24, 0, 4'd1,  16'h0061};
    tbl[6]  = '{16'h0002, 40, 1, 4'd2,  16'h0612};
    tbl[7]  = '{16'h0000, 24, 0, 4'd2,  16'h0612};
    tbl[8]  = '{16'h0004, 40, 1, 4'd3,  16'h6123};
    tbl[9]  = '{16'h0000, 24, 0, 4'd3,  16'h6123};
    tbl[10] = '{16'h0010, 40, 1, 4'd4,  16'h1234};
    tbl[11] = '{16'h0000, 24, 0, 4'd4,  16'h1234};
    tbl[12] = '{16'h0020, 40, 1, 4'd5,  16'h2345};
    tbl[13] = '{16'h0000, 24, 0, 4'd5,  16'h2345};
    tbl[14] = '{16'h1000, 40, 1, 4'd14, 16'h0000};
    tbl[15] = '{16'h0000, 24, 0, 4'd14, 16'h0000};
    tbl[16] = '{16'h0100, 40, 1, 4'd7,  16'h0007};
    tbl[17] = '{16'h0000, 24, 0, 4'd7,  16'h0007};
    tbl[18] = '{16'h0008, 40, 1, 4'd10, 16'h0007};
    tbl[19] = '{16'h0000, 24, 0, 4'd10, 16'h0007};
    tbl[20] = '{16'h2200, 40, 1, 4'd8,  16'h0078};
    tbl[21] = '{16'h0000, 24, 0, 4'd8,  16'h0078};
    // reset values and idle column rotation
    do_reset();
    chk("reset col", {12'h0, kp.col_o}, 16'h000E);
    chk("reset valid", {15'h0, kp.key_valid_o}, 16'h0000);
    chk("reset code", {12'h0, kp.key_code_o}, 16'h0000);
    chk("reset bcd", kp.bcd_o, 16'h0000);
    run(4, p); chk("rotate col1", {12'h0, kp.col_o}, 16'h000D);
    run(4, p); chk("rotate col2", {12'h0, kp.col_o}, 16'h000B);
    run(4, p); chk("rotate col3", {12'h0, kp.col_o}, 16'h0007);
    run(4, p); chk("rotate col0", {12'h0, kp.col_o}, 16'h000E);
    // one-tick bounce on row 0 at column 0
    do_reset();
    direct_row = 4'b1110;
    run(4, p);
    chk("bounce hold col", {12'h0, kp.col_o}, 16'h000E);
    direct_row = 4'hF;
    run(4, q);
    chk("bounce advance col", {12'h0, kp.col_o}, 16'h000D);
    chk("bounce pulses", 16'(p + q), 16'h0000);
    // reset after two low ticks aborts the debounce
    do_reset();
    direct_row = 4'b1110;
    run(8, p);
    rst = 1'b1;
    run(1, q);
    chk("mid-reset pulses", 16'(p + q), 16'h0000);
    chk("mid-reset col", {12'h0, kp.col_o}, 16'h000E);
    chk("mid-reset code", {12'h0, kp.key_code_o}, 16'h0000);
    rst = 1'b0;
    run(11, p);
    chk("fresh debounce early", 16'(p), 16'h0000);
    run(1, p);
    chk("fresh debounce pulse", 16'(p), 16'h0001);
    chk("fresh debounce code", {12'h0, kp.key_code_o}, 16'h0001);
    chk("fresh debounce bcd", kp.bcd_o, ACC ? 16'h0001 : 16'h0000);
    run(1, p);
    chk("pulse width", 16'(p), 16'h0000);
    direct_row = 4'hF;
    run(24, p);
    // keypad-model table: presses and releases
    direct_en = 1'b0;
    do_reset();
    for (int i = 0; i < 22; i++) begin
      keys = tbl[i].keys;
      run(tbl[i].cycles, p);
      chk($sformatf("vec%0d pulses", i), 16'(p), 16'(tbl[i].pulses));
      chk($sformatf("vec%0d code", i), {12'h0, kp.key_code_o}, {12'h0, tbl[i].code});
      chk($sformatf("vec%0d bcd", i), kp.bcd_o, ACC ? tbl[i].bcd : 16'h0000);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad by driving one column at a time and sampling the rows. Debounces presses and releases and emits a one-cycle key event with a 4-bit key code. Optionally accumulates numeric keys into a 4-digit BCD word. It is the input-side counterpart of the 4-digit multiplexed 7-segment display driver: it produces the `bcd` word that the display consumes.

## Interface
- `SCAN_PERIOD`, default 27000: clock cycles per scan tick; minimum 2.
- `DEBOUNCE_TICKS`, default 4: consecutive ticks a row must be stable to accept a press or a release; minimum 1.
- `clk_i`, input, 1: the block's single clock.
- `rst_i`, input, 1: synchronous, active-high reset.
- `row_i`, input, 4: keypad rows; active-low, pulled up externally, asynchronous.
- `col_o`, output, 4: column drive; active-low, exactly one bit low at all times.
- `key_valid_o`, output, 1: one-cycle pulse per accepted press.
- `key_code_o`, output, 4: code of the last accepted key; held between pulses.
- `bcd_o`, output, 16: four BCD digits; `[3:0]` is the newest digit.

## Operation
- **Row synchronizer.** `row_i` passes through a 2-flop synchronizer. All decisions below use the synchronized rows.
- **Tick counter.** Counts down from SCAN_PERIOD-1 to 0, then reloads. `tick` is high for one cycle when the count is 0.
- **Column index c (0..3).** `col_o` = ~(1<<c).
- **Key map.** Row r, column c gives position 4r+c, decoded as follows:
  - Row 0: 1, 2, 3, A.
  - Row 1: 4, 5, 6, B.
  - Row 2: 7, 8, 9, C.
  - Row 3: *, 0, #, D.
  - Codes: digits give their value; A=10, B=11, C=12, D=13, *=14, #=15.
- **FSM states.** SCAN, DEBOUNCE, HELD. All transitions happen on tick cycles only.
  - **SCAN.** If any synchronized row is low:
    - Latch the lowest-index low row as r_lock.
    - Set cnt=1 and go to DEBOUNCE. Do not advance c.
    - If no row is low, advance c = c+1 mod 4.
  - **DEBOUNCE.** If row r_lock is low:
    - If cnt == DEBOUNCE_TICKS-1 or DEBOUNCE_TICKS == 1: pulse `key_valid_o`, load `key_code_o`, set cnt=0, go to HELD.
    - Otherwise increment cnt.
    - If row r_lock is high: go to SCAN and advance c.
  - **HELD.** If row r_lock is high, increment cnt; when cnt reaches DEBOUNCE_TICKS, go to SCAN and advance c. If row r_lock is low, set cnt=0.
- **DEBOUNCE_TICKS == 1.** The SCAN detection tick moves directly to HELD with the pulse.
- **Simultaneous keys.**
  - Several low rows in one column: the lowest row index wins.
  - Keys in other columns are ignored until the locked key is released.
  - Other rows in the locked column are ignored while in DEBOUNCE or HELD.
- **Autorepeat.** None. Exactly one pulse per press.

## Timing
- **Reset values (cycle after `rst_i` is high at an edge):**
  - `col_o`=4'b1110, `key_valid_o`=0, `key_code_o`=0, `bcd_o`=0.
  - State SCAN, c=0, tick counter=SCAN_PERIOD-1, synchronizer=4'b1111.
- **Reset mid-operation.** Aborts any debounce. No pulse is issued during or after the reset cycle.
- **Synchronizer latency.** A change on `row_i` is visible to the FSM 2 cycles later.
- **Press latency.** `key_valid_o` rises in the cycle after the DEBOUNCE_TICKS-th consecutive low tick, counting the SCAN detection tick. It lasts exactly 1 cycle.
- **Output update.** `key_code_o` and `bcd_o` update on the same edge that raises `key_valid_o`.
- **Column change.** A column change takes effect on `col_o` the cycle after a tick. The row sample for the new column occurs SCAN_PERIOD cycles later, which gives the rows time to settle.
- **Minimum re-press interval.** DEBOUNCE_TICKS release ticks plus the scan back to the column.

## Configuration
- Macro `KEYPAD_BCD_ACCUM_EN`.
- **Defined:** on each `key_valid_o` pulse:
  - Code 0..9: `bcd_o` <= {`bcd_o`[11:0], code}; the oldest digit is dropped.
  - Code 14 (*): `bcd_o` <= 0.
  - Any other code: no change.
- **Undefined:** the accumulator is not built and `bcd_o` is constant 0. Scanning, debounce and key events are unchanged.

## Test plan
All scenarios use SCAN_PERIOD=4 and DEBOUNCE_TICKS=3.
- **Reset.** Assert `rst_i` for 2 cycles with all rows high. Required: `col_o`=1110 and all outputs 0. With no key pressed, `col_o` then rotates 1110→1101→1011→0111→1110 every 4 cycles.
- **Single press.** Hold row 1 low while column 2 is driven, through 3 ticks. Required: exactly one `key_valid_o` pulse with `key_code_o`=6. With the macro defined, `bcd_o`=0x0006. No further pulse while held.
- **Bounce rejection.** Row 0 at column 0 goes low for 1 tick, then high. Required: no pulse, FSM back to SCAN, `col_o` advances to 1101.
- **Entry sequence (macro defined).** Press 1, 2, 3, 4, 5, each separated by a full release. Required: `bcd_o`=0x2345. Then press `*`: `bcd_o`=0x0000. Pressing A leaves `bcd_o` unchanged.
- **Two keys in one column.** Rows 2 and 3 held low together at column 1. Required: `key_code_o`=8, with one pulse only.
- **Reset during DEBOUNCE.** Assert `rst_i` after 2 low ticks. Required: no pulse, reset values, and a fresh 3-tick debounce is needed afterwards.
